// File: rtl/btn_event_pkg.sv
// -----------------------------------------------------------------------------
// btn_event_pkg
// Shared constants for the button event path. The debouncers, the event queue
// and every consumer of button presses import this package, so they all use the
// same button numbering and the same event code width.
//   BTN_*            : button index constants (also the evt_code values)
//   NUM_BTN_DEFAULT  : number of buttons on the board
//   EVT_CODE_W       : width of an event code for NUM_BTN_DEFAULT buttons
// -----------------------------------------------------------------------------
package btn_event_pkg;

    localparam int NUM_BTN_DEFAULT = 5;

    localparam int BTN_C = 0;  // centre, highest priority
    localparam int BTN_U = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_D = 4;

    localparam int EVT_CODE_W = $clog2(NUM_BTN_DEFAULT);

    typedef logic [EVT_CODE_W-1:0] evt_code_t;

endpackage : btn_event_pkg

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO. The head entry is presented combinationally
// from storage; occupancy is tracked in a registered counter, and full/empty
// are derived from that counter, so the pointers are allowed to wrap freely.
// A push and a pop on the same edge both take effect, even when full.
//   clock_100mhz : clock
//   reset        : synchronous, active-high
//   push         : write push_data on this edge (ignored if full and no pop)
//   push_data    : entry to write
//   pop          : drop the head on this edge (ignored if empty)
//   head_valid   : FIFO holds at least one entry
//   head_data    : head entry, 0 when empty
//   count        : occupied entries, 0..DEPTH
//   full         : count == DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8
) (
    input  logic                     clock_100mhz,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     head_valid,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              empty;
    logic              do_pop;
    logic              do_push;

    assign empty      = (count == '0);
    assign full       = (count == FULL_COUNT);
    assign head_valid = !empty;
    assign head_data  = empty ? '0 : mem[rd_ptr];

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock_100mhz) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; stale contents are never
    // visible because head_data is masked by the count-derived empty flag.
    always_ff @(posedge clock_100mhz) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule : sync_fifo

// File: rtl/btn_event_queue.sv
// -----------------------------------------------------------------------------
// btn_event_queue
// Collects one-cycle press pulses from the per-button debouncers into an
// ordered event queue. Each button has a pending bit; a fixed-priority arbiter
// (lowest index wins) moves one pending press per edge into a show-ahead FIFO.
// When the FIFO is full the pending bits simply hold (backpressure). A press
// arriving while its button's press is still pending and not leaving on that
// edge cannot be stored separately: it merges and the sticky overflow flag is
// raised.
//   clock_100mhz   : clock
//   reset          : synchronous, active-high; discards queued and pending
//   btn_pulse      : one-cycle press pulses, index = BTN_* code
//   evt_valid      : queue head valid
//   evt_code       : button index at the queue head (0 when empty)
//   evt_ready      : consumer accepts the head (pop on evt_valid && evt_ready)
//   evt_count      : occupied queue entries, 0..DEPTH
//   overflow       : sticky, at least one press was lost
//   clear_overflow : clears overflow (a simultaneous new loss wins)
// -----------------------------------------------------------------------------
module btn_event_queue
    import btn_event_pkg::*;
#(
    parameter int NUM_BTN = NUM_BTN_DEFAULT,
    parameter int DEPTH   = 8
) (
    input  logic                       clock_100mhz,
    input  logic                       reset,
    input  logic [NUM_BTN-1:0]         btn_pulse,
    output logic                       evt_valid,
    output logic [$clog2(NUM_BTN)-1:0] evt_code,
    input  logic                       evt_ready,
    output logic [$clog2(DEPTH):0]     evt_count,
    output logic                       overflow,
    input  logic                       clear_overflow
);

    localparam int CODE_W = $clog2(NUM_BTN);

    logic [NUM_BTN-1:0] pending_q;
    logic [NUM_BTN-1:0] grant;
    logic [NUM_BTN-1:0] push_mask;
    logic [CODE_W-1:0]  grant_code;
    logic               any_pending;
    logic               fifo_full;
    logic               pop;
    logic               push;
    logic               merge;

    // Fixed-priority arbiter: scan from the top so the lowest set index is the
    // last (and therefore winning) assignment.
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        grant      = '0;
        grant_code = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                grant      = '0;
                grant[i]   = 1'b1;
                grant_code = CODE_W'(i);
            end
        end
    end

    assign any_pending = |pending_q;
    assign pop         = evt_valid && evt_ready;
    assign push        = any_pending && (!fifo_full || pop);
    assign push_mask   = push ? grant : '0;

    // A pulse on a button that is pending and not leaving this edge is lost.
    assign merge = |(btn_pulse & pending_q & ~push_mask);

    always_ff @(posedge clock_100mhz) begin
        if (reset) begin
            pending_q <= '0;
            overflow  <= 1'b0;
        end else begin
            // A pulse on the bit being pushed re-arms it as a fresh press.
            pending_q <= (pending_q & ~push_mask) | btn_pulse;
            if (merge)
                overflow <= 1'b1;
            else if (clear_overflow)
                overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock_100mhz (clock_100mhz),
        .reset        (reset),
        .push         (push),
        .push_data    (grant_code),
        .pop          (pop),
        .head_valid   (evt_valid),
        .head_data    (evt_code),
        .count        (evt_count),
        .full         (fifo_full)
    );

endmodule : btn_event_queue
